// File: rtl/row_reduce_accumulator.sv
// row_reduce_accumulator
// Reduces NO_OF_UNITS signed lanes per chunk through a registered pairwise
// adder tree, then accumulates consecutive chunks of one matrix row into a
// single row sum.
// Build option: define SATURATE_EN for signed saturating addition in every
// tree node and in the accumulator; otherwise addition wraps.
// Latency: out_valid pulses L+1 edges after the edge that samples the last
// chunk of a row, where L = log2(NO_OF_UNITS). It is the same in both builds.
module row_reduce_accumulator #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int ROW_CNT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] adder_row_input,
    output logic [ELEMENT_WIDTH-1:0]             adder_output,
    output logic                                 out_valid,
    output logic                                 busy,
    output logic [ROW_CNT_WIDTH-1:0]             rows_done
);

    localparam int W = ELEMENT_WIDTH;
    localparam int N = NO_OF_UNITS;
    localparam int L = $clog2(NO_OF_UNITS);

    // Signed add; clamps to the extreme representable value on overflow
    // when saturation is built in, wraps otherwise.
    function automatic logic [W-1:0] add_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        s = a + b;
`ifdef SATURATE_EN
        if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) begin
            s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // A low start clears the pipeline exactly like reset, but the result
    // register and the row counter survive it.
    logic flush;
    assign flush = rst | ~start;

    // Input lanes, lane 0 in the LSBs.
    logic [W-1:0] lane_w [0:N-1];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign lane_w[gi] = adder_row_input[gi*W +: W];
        end
    endgenerate

    // The tree is laid out as a heap. Nodes N..2N-1 are the registered
    // leaves. Node i holds the sum of nodes 2i and 2i+1 from the previous
    // cycle. Node 1 is the root.
    logic [W-1:0] node_q [1:2*N-1];

    // Bit k of these tags describes the chunk held at tree level k:
    // level 0 is the leaves and level L is the root.
    logic [L:0] lvl_vld_q;
    logic [L:0] lvl_last_q;

    // Tree data registers: capture the lanes and add sibling pairs level by level.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 1; i < 2*N; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            for (int i = N; i < 2*N; i++) begin
                node_q[i] <= lane_w[i-N];
            end
            for (int i = 1; i < N; i++) begin
                node_q[i] <= add_fn(node_q[2*i], node_q[2*i+1]);
            end
        end
    end

    // Valid/last tags travel down the tree in step with the data.
    always_ff @(posedge clk) begin
        if (flush) begin
            lvl_vld_q  <= '0;
            lvl_last_q <= '0;
        end else begin
            lvl_vld_q  <= {lvl_vld_q[L-1:0], in_valid};
            lvl_last_q <= {lvl_last_q[L-1:0], in_valid & in_last};
        end
    end

    logic [W-1:0] root_w;
    assign root_w = node_q[1];

    logic [W-1:0]             acc_q, acc_d;
    logic                     first_q, first_d;
    logic [W-1:0]             out_q, out_d;
    logic                     ov_q, ov_d;
    logic [ROW_CNT_WIDTH-1:0] rows_q, rows_d;

    // Accumulator next state. A last chunk closes the row and leaves the
    // accumulator clean, so the next row's first chunk needs no bubble.
    always_comb begin
        acc_d   = acc_q;
        first_d = first_q;
        out_d   = out_q;
        ov_d    = 1'b0;
        rows_d  = rows_q;
        if (lvl_vld_q[L]) begin
            if (lvl_last_q[L]) begin
                out_d   = first_q ? root_w : add_fn(acc_q, root_w);
                ov_d    = 1'b1;
                rows_d  = rows_q + 1'b1;
                first_d = 1'b1;
                acc_d   = '0;
            end else begin
                acc_d   = first_q ? root_w : add_fn(acc_q, root_w);
                first_d = 1'b0;
            end
        end
    end

    // Accumulator and output registers. A low start keeps the last result and the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            first_q <= 1'b1;
            out_q   <= '0;
            ov_q    <= 1'b0;
            rows_q  <= '0;
        end else if (!start) begin
            acc_q   <= '0;
            first_q <= 1'b1;
            ov_q    <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            first_q <= first_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            rows_q  <= rows_d;
        end
    end

    assign adder_output = out_q;
    assign out_valid    = ov_q;
    assign rows_done    = rows_q;
    assign busy         = (|lvl_vld_q) | ~first_q;

endmodule

// File: tb/tb_row_reduce_accumulator.sv
// Testbench for row_reduce_accumulator. The DUT is built with 8 lanes of
// 32 bits and a 2-bit row counter, so counter wrap is exercised.
// Directed rows come first, then random traffic with gaps, resets and
// start drops.
module tb_row_reduce_accumulator;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int RC = 2;
    localparam int L  = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_last;
    logic [N*W-1:0]   adder_row_input;
    logic [W-1:0]     adder_output;
    logic             out_valid;
    logic             busy;
    logic [RC-1:0]    rows_done;

    row_reduce_accumulator #(
        .ELEMENT_WIDTH(W),
        .NO_OF_UNITS  (N),
        .ROW_CNT_WIDTH(RC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .adder_row_input(adder_row_input),
        .adder_output   (adder_output),
        .out_valid      (out_valid),
        .busy           (busy),
        .rows_done      (rows_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           due;
        logic [W-1:0] val;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] row_acc;
    bit           row_open;
    logic [W-1:0] exp_out;
    logic [RC-1:0] exp_rows;
    int           last_valid_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference signed add on integers, clamped or wrapped to 32 bits.
    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef SATURATE_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[W-1:0];
    endfunction

    // Chunk sum: halve the list by pairing neighbours until one value remains.
    function automatic logic [W-1:0] ref_chunk(input logic [N*W-1:0] d);
        logic [W-1:0] v[N];
        for (int i = 0; i < N; i++) v[i] = d[i*W +: W];
        for (int n = N; n > 1; n = n / 2)
            for (int i = 0; i < n / 2; i++) v[i] = ref_add(v[2*i], v[2*i+1]);
        return v[0];
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] x);
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = x;
        return d;
    endfunction

    function automatic logic [N*W-1:0] ramp(input logic [W-1:0] base);
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = base + W'(i);
        return d;
    endfunction

    // Drive one cycle, advance the model across the edge, then compare.
    task automatic step(input bit r, input bit st, input bit v, input bit l, input logic [N*W-1:0] d);
        bit pulse;
        rst = r; start = st; in_valid = v; in_last = l; adder_row_input = d;
        @(posedge clk);
        cyc++;
        if (r || !st) begin
            exp_q.delete();
            row_open = 1'b0;
            row_acc = '0;
            last_valid_cyc = -1000;
            if (r) begin
                exp_out = '0;
                exp_rows = '0;
            end
        end else if (v) begin
            row_acc = row_open ? ref_add(row_acc, ref_chunk(d)) : ref_chunk(d);
            row_open = 1'b1;
            last_valid_cyc = cyc;
            if (l) begin
                exp_q.push_back('{due: cyc + L + 1, val: row_acc});
                row_open = 1'b0;
            end
        end
        #1;
        pulse = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            pulse = 1'b1;
            exp_out = exp_q[0].val;
            exp_rows = exp_rows + 1'b1;
            void'(exp_q.pop_front());
        end
        check("out_valid", 32'(out_valid), 32'(pulse));
        check("adder_output", adder_output, exp_out);
        check("rows_done", 32'(rows_done), 32'(exp_rows));
        check("busy", 32'(busy), 32'(row_open || (cyc - last_valid_cyc <= L)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [N*W-1:0] d;
        row_acc = '0; row_open = 1'b0; exp_out = '0; exp_rows = '0; last_valid_cyc = -1000;

        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(1);

        // Single-chunk row: lanes 1..8.
        step(1'b0, 1'b1, 1'b1, 1'b1, ramp(32'd1));
        idle(5);
        check("single_row", adder_output, 32'd36);

        // Two-chunk row: lanes 1..8, then all tens.
        step(1'b0, 1'b1, 1'b1, 1'b0, ramp(32'd1));
        step(1'b0, 1'b1, 1'b1, 1'b1, fill(32'd10));
        idle(5);
        check("two_chunk_row", adder_output, 32'd116);

        // Row A with a 2-cycle gap, then row B back to back.
        step(1'b0, 1'b1, 1'b1, 1'b0, fill(32'd1));
        idle(2);
        step(1'b0, 1'b1, 1'b1, 1'b1, fill(32'd2));
        step(1'b0, 1'b1, 1'b1, 1'b1, fill(32'd3));
        idle(6);
        check("back_to_back", adder_output, 32'd24);

        // Reset mid-row discards the partial row.
        step(1'b0, 1'b1, 1'b1, 1'b0, fill(32'd5));
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("busy_after_rst", 32'(busy), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, fill(32'd1));
        idle(5);
        check("after_reset_row", adder_output, 32'd8);

        // A start drop mid-row discards the partial row and keeps the result.
        step(1'b0, 1'b1, 1'b1, 1'b0, fill(32'd4));
        step(1'b0, 1'b0, 1'b1, 1'b1, fill(32'd9));
        step(1'b0, 1'b1, 1'b1, 1'b1, fill(32'd1));
        idle(5);
        check("after_start_drop", adder_output, 32'd8);

        // Overflow in the first tree level.
        d = '0;
        d[W-1:0] = 32'h7FFF_FFFF;
        d[2*W-1:W] = 32'd1;
        step(1'b0, 1'b1, 1'b1, 1'b1, d);
        idle(5);
`ifdef SATURATE_EN
        check("overflow", adder_output, 32'h7FFF_FFFF);
`else
        check("overflow", adder_output, 32'h8000_0000);
`endif

        // Random traffic with gaps, occasional resets and start drops.
        for (int t = 0; t < 400; t++) begin
            bit r, st, v, l;
            r  = ($urandom_range(0, 79) == 0);
            st = ($urandom_range(0, 39) != 0);
            v  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: d[i*W +: W] = 32'($urandom_range(0, 20));
                    1: d[i*W +: W] = $urandom;
                    2: d[i*W +: W] = 32'h7FFF_FFFF;
                    default: d[i*W +: W] = 32'h8000_0000;
                endcase
            end
            step(r, st, v, l, d);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
